// File: rtl/hilo_muldiv_unit.sv
// HI/LO multiply/divide unit: iterative 32-cycle shift-add multiply and restoring divide,
// followed by one sign-fix cycle that writes the 64-bit result into HI/LO.
module hilo_muldiv_unit (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  localparam logic [2:0] OP_MTHI = 3'd4;
  localparam logic [2:0] OP_MTLO = 3'd5;

  state_t      state, state_next;
  logic [4:0]  cnt;
  logic [31:0] a_mag, b_mag;
  logic [31:0] acc_hi, acc_lo;
  logic        is_div, neg_res, neg_rem;

  logic        accept_md, is_signed;
  logic [31:0] rs_abs, rt_abs;
  logic [32:0] mul_sum, div_shift;
  logic        div_ge;
  logic [31:0] step_hi, step_lo;
  logic [63:0] prod_fix;
  logic [31:0] quo_fix, rem_fix, fix_hi, fix_lo;

  // ops 0-3 have op[2]=0; even codes (MULT, DIV) are the signed variants
  assign accept_md = (state == IDLE) && start && !op[2];
  assign is_signed = !op[0];
  assign rs_abs    = (is_signed && rs[31]) ? -rs : rs;
  assign rt_abs    = (is_signed && rt[31]) ? -rt : rt;
  assign busy      = (state != IDLE);

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) state <= IDLE;
    else      state <= state_next;
  end

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept_md) state_next = RUN;
      RUN:     if (cnt == 5'd31) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // One iteration: {acc_hi,acc_lo} is product/multiplier for multiply, remainder/quotient for divide.
  always_comb begin
    mul_sum   = acc_lo[0] ? ({1'b0, acc_hi} + {1'b0, a_mag}) : {1'b0, acc_hi};
    div_shift = {acc_hi, acc_lo[31]};
    div_ge    = (div_shift >= {1'b0, b_mag});
    if (is_div) begin
      step_hi = div_ge ? (div_shift[31:0] - b_mag) : div_shift[31:0];
      step_lo = {acc_lo[30:0], div_ge};
    end else begin
      step_hi = mul_sum[32:1];
      step_lo = {mul_sum[0], acc_lo[31:1]};
    end
  end

  // A zero divisor leaves the dividend in the remainder; re-signing it restores rs exactly.
  always_comb begin
    prod_fix = neg_res ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
    quo_fix  = (b_mag == 32'd0) ? 32'hFFFF_FFFF : (neg_res ? -acc_lo : acc_lo);
    rem_fix  = neg_rem ? -acc_hi : acc_hi;
    fix_hi   = is_div ? rem_fix : prod_fix[63:32];
    fix_lo   = is_div ? quo_fix : prod_fix[31:0];
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      cnt     <= '0;
      a_mag   <= '0;
      b_mag   <= '0;
      acc_hi  <= '0;
      acc_lo  <= '0;
      is_div  <= 1'b0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      hi      <= '0;
      lo      <= '0;
      done    <= 1'b0;
    end else begin
      done <= (state == FIX);
      case (state)
        IDLE: begin
          if (accept_md) begin
            a_mag   <= rs_abs;
            b_mag   <= rt_abs;
            is_div  <= op[1];
            neg_res <= is_signed && (rs[31] ^ rt[31]);
            neg_rem <= is_signed && rs[31];
            acc_hi  <= '0;
            acc_lo  <= op[1] ? rs_abs : rt_abs;
            cnt     <= '0;
          end else if (start && op == OP_MTHI) begin
            hi <= rs;
          end else if (start && op == OP_MTLO) begin
            lo <= rs;
          end
        end
        RUN: begin
          acc_hi <= step_hi;
          acc_lo <= step_lo;
          cnt    <= cnt + 5'd1;
        end
        FIX: begin
          hi <= fix_hi;
          lo <= fix_lo;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Self-checking bench for hilo_muldiv_unit: directed corner cases plus randomized ops
// compared against a plain-arithmetic HI/LO reference model.
module tb_hilo_muldiv_unit;

  logic        Clk, Rst, start;
  logic [2:0]  op;
  logic [31:0] rs, rt;
  logic        busy, done;
  logic [31:0] hi, lo;

  int n_checks = 0;
  int n_err    = 0;
  logic [31:0] model_hi = '0;
  logic [31:0] model_lo = '0;

  hilo_muldiv_unit dut (
    .Clk(Clk), .Rst(Rst), .start(start), .op(op), .rs(rs), .rt(rt),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: {hi,lo} from ordinary 64-bit arithmetic.
  function automatic logic [63:0] ref_md(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] res;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    res = '0;
    case (o)
      3'd0: res = sa * sb;
      3'd1: res = {32'd0, a} * {32'd0, b};
      3'd2: begin
        if (b == 0) res = {a, 32'hFFFF_FFFF};
        else begin
          q = sa / sb;
          r = sa % sb;
          res = {r[31:0], q[31:0]};
        end
      end
      3'd3: begin
        if (b == 0) res = {a, 32'hFFFF_FFFF};
        else res = {a % b, a / b};
      end
      default: res = {model_hi, model_lo};
    endcase
    return res;
  endfunction

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic launch(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; op = o; rs = a; rt = b;
    @(negedge Clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int exp_lat, input logic [63:0] exp_res);
    int  n;
    bit  got, unstable, idle_seen;
    n = 0; got = 0; unstable = 0; idle_seen = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge Clk);
      if (done) begin n = i; got = 1; break; end
      if (hi !== model_hi || lo !== model_lo) unstable = 1;
      if (busy !== 1'b1) idle_seen = 1;
    end
    check({tag, "_latency"}, n, exp_lat);
    check({tag, "_hilo_stable"}, unstable, 0);
    check({tag, "_busy_run"}, idle_seen, 0);
    check({tag, "_busy_end"}, busy, 0);
    check({tag, "_hilo"}, {hi, lo}, exp_res);
    if (got) {model_hi, model_lo} = exp_res;
  endtask

  task automatic run_md(input string tag, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    launch(o, a, b);
    wait_done(tag, 33, ref_md(o, a, b));
  endtask

  task automatic run_mt(input string tag, input logic [2:0] o, input logic [31:0] a);
    start = 1'b1; op = o; rs = a; rt = $urandom;
    @(negedge Clk);
    start = 1'b0;
    if (o == 3'd4) model_hi = a;
    else if (o == 3'd5) model_lo = a;
    check({tag, "_hilo"}, {hi, lo}, {model_hi, model_lo});
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return $urandom_range(0, 20);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    bit saw_done;
    Rst = 1'b0; start = 1'b0; op = '0; rs = '0; rt = '0;
    repeat (3) @(negedge Clk);
    check("reset_state", {busy, done, hi, lo}, '0);
    Rst = 1'b1;
    @(negedge Clk);

    run_md("multu_max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("multu_max_exact", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
    @(negedge Clk);
    check("done_one_cycle", done, 0);

    run_md("mult_neg", 3'd0, 32'hFFFF_FFFD, 32'd7);
    check("mult_neg_exact", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
    run_md("div_neg", 3'd2, 32'hFFFF_FFF9, 32'd2);
    check("div_neg_exact", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    run_md("divu", 3'd3, 32'd100, 32'd7);
    check("divu_exact", {hi, lo}, {32'd2, 32'd14});
    run_md("divu_zero", 3'd3, 32'd5, 32'd0);
    check("divu_zero_exact", {hi, lo}, {32'd5, 32'hFFFF_FFFF});
    run_md("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    check("div_ovf_exact", {hi, lo}, {32'd0, 32'h8000_0000});
    run_md("div_zero_neg", 3'd2, 32'hFFFF_FFF0, 32'd0);

    run_mt("mthi", 3'd4, 32'h1234_5678);
    check("mthi_exact", hi, 32'h1234_5678);
    run_mt("mtlo", 3'd5, 32'hCAFE_F00D);
    run_mt("nop6", 3'd6, 32'h5555_AAAA);
    run_mt("nop7", 3'd7, 32'hAAAA_5555);

    // MTLO and a new MULT while busy must both be ignored.
    launch(3'd1, 32'd123456, 32'd654321);
    repeat (5) @(negedge Clk);
    start = 1'b1; op = 3'd5; rs = 32'hDEAD_BEEF;
    @(negedge Clk);
    op = 3'd0; rs = 32'd7; rt = 32'd9;
    @(negedge Clk);
    start = 1'b0;
    wait_done("busy_ignore", 26, ref_md(3'd1, 32'd123456, 32'd654321));

    // Reset in the middle of a multiply.
    @(negedge Clk);
    launch(3'd1, 32'hFFFF_FFFF, 32'h1234_5678);
    repeat (9) @(negedge Clk);
    Rst = 1'b0;
    #1;
    check("abort_state", {busy, done, hi, lo}, '0);
    model_hi = '0; model_lo = '0;
    @(negedge Clk);
    Rst = 1'b1;
    saw_done = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge Clk);
      if (done) saw_done = 1;
    end
    check("abort_no_done", {saw_done, hi, lo}, '0);
    Rst = 1'b0;
    @(negedge Clk);
    Rst = 1'b1;
    run_md("post_reset_divu", 3'd3, 32'd9, 32'd4);
    check("post_reset_exact", {hi, lo}, {32'd1, 32'd2});

    // Back-to-back: second start issued in the done cycle.
    launch(3'd0, 32'hFFFF_0000, 32'h0001_0001);
    wait_done("b2b_first", 33, ref_md(3'd0, 32'hFFFF_0000, 32'h0001_0001));
    launch(3'd2, 32'd1000, 32'hFFFF_FFFD);
    wait_done("b2b_second", 33, ref_md(3'd2, 32'd1000, 32'hFFFF_FFFD));

    for (int k = 0; k < 30; k++) begin
      logic [2:0]  o;
      logic [31:0] a, b;
      o = 3'($urandom_range(0, 7));
      a = pick();
      b = pick();
      if (o <= 3'd3) run_md($sformatf("rand%0d_op%0d", k, o), o, a, b);
      else run_mt($sformatf("rand%0d_op%0d", k, o), o, a);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
